// File: rtl/ext_pkg.sv
// Shared encodings and helpers for the extension unit.
// Mode constants are shared by the datapath and the extension unit.
package ext_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] EXT_ZEXT = 3'd0;
  localparam logic [MODE_W-1:0] EXT_SEXT = 3'd1;
  localparam logic [MODE_W-1:0] EXT_LUI  = 3'd2;
  localparam logic [MODE_W-1:0] EXT_LB   = 3'd3;
  localparam logic [MODE_W-1:0] EXT_LBU  = 3'd4;
  localparam logic [MODE_W-1:0] EXT_LH   = 3'd5;
  localparam logic [MODE_W-1:0] EXT_LHU  = 3'd6;
  localparam logic [MODE_W-1:0] EXT_PASS = 3'd7;

  // Only halfword loads have an alignment constraint; bytes are always aligned.
  function automatic logic ext_misaligned(input logic [MODE_W-1:0] mode, input logic off0);
    return ((mode == EXT_LH) || (mode == EXT_LHU)) && off0;
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational extension datapath: immediate zero/sign/upper extension and
// little-endian byte/halfword load extraction.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  localparam int OFF_W = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [MODE_W-1:0] mode,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] sh;
  logic [7:0]        b;
  logic [15:0]       h;

  assign imm = data[IMM_W-1:0];
  // Shifting the word down by the byte offset puts the selected lane at bit 0.
  assign sh  = data >> {off, 3'b000};
  assign b   = sh[7:0];
  assign h   = sh[15:0];
  assign err = ext_misaligned(mode, off[0]);

  always_comb begin
    result = data;
    case (mode)
      EXT_ZEXT: result = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_SEXT: result = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_LUI:  result = {imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_LB:   result = {{(DATA_W-8){b[7]}}, b};
      EXT_LBU:  result = {{(DATA_W-8){1'b0}}, b};
      EXT_LH:   result = err ? '0 : {{(DATA_W-16){h[15]}}, h};
      EXT_LHU:  result = err ? '0 : {{(DATA_W-16){1'b0}}, h};
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/ext_pipe_unit.sv
// Registered, handshaked extension stage: 1-cycle latency with a main entry
// driving the outputs and a skid entry so in_ready can be a pure register.
module ext_pipe_unit
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5,
  localparam int OFF_W = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [TAG_W-1:0]  out_tag
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  ent_t              main_q, skid_q, nxt;
  logic              main_v, skid_v;
  logic [DATA_W-1:0] core_res;
  logic              core_err;

  ext_core #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_core (
    .data   (in_data),
    .mode   (in_mode),
    .off    (in_off),
    .result (core_res),
    .err    (core_err)
  );

  assign nxt       = '{data: core_res, err: core_err, tag: in_tag};
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_q.data;
  assign out_err   = main_q.err;
  assign out_tag   = main_q.tag;

  // Skid only fills while main is stalled, so an accept with skid_v set is impossible.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else if (in_valid) begin
        main_q <= nxt;
        main_v <= 1'b1;
      end else begin
        main_v <= 1'b0;
      end
    end else if (in_valid && !skid_v) begin
      skid_q <= nxt;
      skid_v <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Scoreboard bench for ext_pipe_unit: directed vectors, decoupled monitor.
module tb_ext_pipe_unit;
  import ext_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [2:0]  in_mode;
  logic [1:0]  in_off;
  logic [4:0]  in_tag;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  logic        in_valid64, out_ready64, in_ready64, out_valid64, out_err64;
  logic [63:0] in_data64, out_data64;
  logic [2:0]  in_mode64, in_off64;
  logic [4:0]  in_tag64, out_tag64;

  ext_pipe_unit dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_off(in_off), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_tag(out_tag)
  );

  ext_pipe_unit #(.DATA_W(64), .IMM_W(16)) dut64 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_data(in_data64),
    .in_mode(in_mode64), .in_off(in_off64), .in_tag(in_tag64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64),
    .out_err(out_err64), .out_tag(out_tag64)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic [4:0]  t;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  m;
    logic [1:0]  o;
    logic [4:0]  t;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready now.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_out: got tag %0d data %h, expected no output", out_tag, out_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_data", {32'd0, out_data}, {32'd0, e.d});
        chk("out_err",  {63'd0, out_err},  {63'd0, e.e});
        chk("out_tag",  {59'd0, out_tag},  {59'd0, e.t});
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [2:0] m, input logic [1:0] o,
                      input logic [4:0] t, input logic [31:0] ed, input logic ee, input bit push);
    int n;
    bit ok;
    n = 0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_off = o; in_tag = t;
    do begin
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      nvec++;
      nmis++;
      $display("FAIL send_timeout: tag %0d not accepted, expected accept within 50 cycles", t);
    end else if (push) begin
      sbq.push_back('{d: ed, e: ee, t: t});
    end
    in_valid = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h0000_8001, EXT_ZEXT, 2'd0, 5'd20, 32'h0000_8001, 1'b0};
    vecs[1] = '{32'h0000_8001, EXT_SEXT, 2'd0, 5'd21, 32'hFFFF_8001, 1'b0};
    vecs[2] = '{32'h0000_8001, EXT_LUI,  2'd0, 5'd22, 32'h8001_0000, 1'b0};
    vecs[3] = '{32'h80F0_7F85, EXT_LB,   2'd0, 5'd23, 32'hFFFF_FF85, 1'b0};
    vecs[4] = '{32'h80F0_7F85, EXT_LBU,  2'd3, 5'd24, 32'h0000_0080, 1'b0};
    vecs[5] = '{32'h80F0_7F85, EXT_LH,   2'd2, 5'd25, 32'hFFFF_80F0, 1'b0};
    vecs[6] = '{32'h80F0_7F85, EXT_LHU,  2'd0, 5'd26, 32'h0000_7F85, 1'b0};
    vecs[7] = '{32'h80F0_7F85, EXT_LH,   2'd1, 5'd27, 32'h0000_0000, 1'b1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_mode = '0; in_off = '0; in_tag = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; in_data64 = '0; in_mode64 = '0;
    in_off64 = '0; in_tag64 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_data",  {32'd0, out_data},  64'd0);
    chk("rst_out_valid64", {63'd0, out_valid64}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single beats back to back, each visible one cycle after accept.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].d, vecs[i].m, vecs[i].o, vecs[i].t, vecs[i].ed, vecs[i].ee, 1'b1);
      chk("lat_valid", {63'd0, out_valid}, 64'd1);
      chk("lat_tag",   {59'd0, out_tag},   {59'd0, vecs[i].t});
    end
    repeat (2) @(posedge clk);
    #1;
    chk("idle_valid", {63'd0, out_valid}, 64'd0);

    // Back-pressure: two beats fill main + skid, then release.
    out_ready = 1'b0;
    send(32'h1111_1111, EXT_PASS, 2'd0, 5'd1, 32'h1111_1111, 1'b0, 1'b1);
    send(32'h2222_2222, EXT_PASS, 2'd0, 5'd2, 32'h2222_2222, 1'b0, 1'b1);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    fork
      begin
        for (int t = 3; t <= 6; t++)
          send({8{t[3:0]}}, EXT_PASS, 2'd0, t[4:0], {8{t[3:0]}}, 1'b0, 1'b1);
      end
      begin
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          chk("bp_tput", {63'd0, out_valid}, 64'd1);
        end
      end
    join
    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
    #1;
    chk("bp_drain", 64'(sbq.size()), 64'd0);

    // Flush with both entries full and a beat offered in the same cycle.
    out_ready = 1'b0;
    send(32'hDEAD_0010, EXT_PASS, 2'd0, 5'd10, 32'h0, 1'b0, 1'b0);
    send(32'hDEAD_0011, EXT_PASS, 2'd0, 5'd11, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 32'hDEAD_0012; in_tag = 5'd12; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready",  {63'd0, in_ready},  64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_idle", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;

    // Reset mid-stream.
    out_ready = 1'b0;
    send(32'h7777_7777, EXT_PASS, 2'd0, 5'd7, 32'h0, 1'b0, 1'b0);
    send(32'h8888_8888, EXT_PASS, 2'd0, 5'd8, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 32'h1234_5678; in_tag = 5'd13; reset = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_out_data",  {32'd0, out_data},  64'd0);
    chk("mrst_out_err",   {63'd0, out_err},   64'd0);
    chk("mrst_out_tag",   {59'd0, out_tag},   64'd0);
    chk("mrst_in_ready",  {63'd0, in_ready},  64'd1);
    reset = 1'b0;
    out_ready = 1'b1;
    send(32'h80F0_7F85, EXT_LBU, 2'd1, 5'd9, 32'h0000_007F, 1'b0, 1'b1);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_tag",   {59'd0, out_tag},   64'd9);
    @(posedge clk); #1;
    chk("post_rst_sole", {63'd0, out_valid}, 64'd0);
    chk("post_rst_drain", 64'(sbq.size()), 64'd0);

    // 64-bit build.
    in_valid64 = 1'b1; in_data64 = 64'h0000_0000_0000_1234; in_mode64 = EXT_LUI; in_tag64 = 5'd3;
    @(posedge clk); #1;
    chk("w64_lui_valid", {63'd0, out_valid64}, 64'd1);
    chk("w64_lui", out_data64, 64'h1234_0000_0000_0000);
    in_data64 = 64'hAB00_0000_0000_0000; in_mode64 = EXT_LBU; in_off64 = 3'd7; in_tag64 = 5'd4;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    chk("w64_lbu", out_data64, 64'h0000_0000_0000_00AB);
    chk("w64_tag", {59'd0, out_tag64}, 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
